// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
//   Shares one flash read controller between two requesters (port 0: CPU
//   fetch, port 1: video/sprite fetch). Each port sees the same level
//   handshake it would get from a private controller: Ready is high when
//   idle, low while the request is serviced, and high again with Data valid.
//   Competing requests are granted round-robin, one flash transaction at a
//   time.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   p0Addr/p1Addr       per-port read address, sampled only when issued
//   p0Enable/p1Enable   per-port request level, held until Ready returns high
//   p0Ready/p1Ready     per-port ready (registered)
//   p0Data/p1Data       per-port read data, valid while Ready=1 after completion
//   flashReadAddr       address to the flash controller (registered)
//   enableFlash         request to the flash controller (registered)
//   flashByteRead       read data from the flash controller
//   flashDataReady      controller ready: falls on accept, rises with data
// -----------------------------------------------------------------------------
module flash_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] p0Addr,
    input  logic              p0Enable,
    output logic              p0Ready,
    output logic [DATA_W-1:0] p0Data,

    input  logic [ADDR_W-1:0] p1Addr,
    input  logic              p1Enable,
    output logic              p1Ready,
    output logic [DATA_W-1:0] p1Data,

    output logic [ADDR_W-1:0] flashReadAddr,
    output logic              enableFlash,
    input  logic [DATA_W-1:0] flashByteRead,
    input  logic              flashDataReady
);

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RELEASE    = 3'd4
    } state_e;

    // Sequencer state
    state_e                 state_q,    state_d;
    logic                   grant_q,    grant_d;     // port owning the flash
    logic                   last_q,     last_d;      // port granted most recently
    logic                   abort_q,    abort_d;     // granted port dropped Enable

    // Per-port handshake state
    logic [NUM_PORTS-1:0]   pending_q,  pending_d;
    logic [NUM_PORTS-1:0]   done_q,     done_d;
    logic [NUM_PORTS-1:0]   ready_q,    ready_d;
    logic [DATA_W-1:0]      p0_data_q,  p0_data_d;
    logic [DATA_W-1:0]      p1_data_q,  p1_data_d;

    // Flash controller side
    logic [ADDR_W-1:0]      addr_q,     addr_d;
    logic                   en_flash_q, en_flash_d;

    // Combinational helpers
    logic [NUM_PORTS-1:0]   en_c;
    logic [NUM_PORTS-1:0]   elig_c;
    logic [NUM_PORTS-1:0]   granted_c;
    logic                   busy_c;
    logic                   aborted_c;

    assign en_c      = {p1Enable, p0Enable};

    // A pending port whose Enable has already fallen is being aborted this
    // cycle, so it must not win arbitration.
    assign elig_c    = pending_q & en_c;

    // The flash is owned by grant_q from ISSUE until the completion update.
    assign busy_c    = (state_q == S_ISSUE) || (state_q == S_WAIT_START) ||
                       (state_q == S_WAIT_DONE);
    assign granted_c = busy_c ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

    // Enable falling at any point of the grant (including the completion
    // cycle itself) turns the returned word into a discard.
    assign aborted_c = abort_q | ~en_c[grant_q];

    // Next-state and per-port bookkeeping
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        abort_d    = abort_q;
        pending_d  = pending_q;
        done_d     = done_q;
        ready_d    = ready_q;
        p0_data_d  = p0_data_q;
        p1_data_d  = p1_data_q;
        addr_d     = addr_q;
        en_flash_d = en_flash_q;

        // Request capture, done release and abort-before-grant per port.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            done_d[i] = done_q[i] & en_c[i];
            if (!pending_q[i]) begin
                // done blocks a held-high Enable from re-requesting
                if (en_c[i] && !done_q[i]) begin
                    pending_d[i] = 1'b1;
                    ready_d[i]   = 1'b0;
                end
            end else if (!granted_c[i] && !en_c[i]) begin
                pending_d[i] = 1'b0;
                ready_d[i]   = 1'b1;
            end
        end

        if (busy_c && !en_c[grant_q]) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (elig_c != '0) begin
                    // Round-robin on a tie, otherwise the lone requester.
                    if (&elig_c) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = elig_c[1];
                    end
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                addr_d     = grant_q ? p1Addr : p0Addr;
                en_flash_d = 1'b1;
                state_d    = S_WAIT_START;
            end

            S_WAIT_START: begin
                if (!flashDataReady) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (flashDataReady) begin
                    en_flash_d         = 1'b0;
                    last_d             = grant_q;
                    abort_d            = 1'b0;
                    pending_d[grant_q] = 1'b0;
                    ready_d[grant_q]   = 1'b1;
                    if (!aborted_c) begin
                        done_d[grant_q] = 1'b1;
                        if (grant_q) begin
                            p1_data_d = flashByteRead;
                        end else begin
                            p0_data_d = flashByteRead;
                        end
                    end
                    state_d = S_RELEASE;
                end
            end

            // Lets the controller observe enableFlash low before any reissue.
            S_RELEASE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            abort_q    <= 1'b0;
            pending_q  <= '0;
            done_q     <= '0;
            ready_q    <= '1;
            p0_data_q  <= '0;
            p1_data_q  <= '0;
            addr_q     <= '0;
            en_flash_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            p0_data_q  <= p0_data_d;
            p1_data_q  <= p1_data_d;
            addr_q     <= addr_d;
            en_flash_q <= en_flash_d;
        end
    end

    assign p0Ready       = ready_q[0];
    assign p1Ready       = ready_q[1];
    assign p0Data        = p0_data_q;
    assign p1Data        = p1_data_q;
    assign flashReadAddr = addr_q;
    assign enableFlash   = en_flash_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_arbiter
//   Drives two requesting ports against a behavioural flash controller and
//   compares per-port data, ready behaviour and the order of flash requests
//   against a transaction-level expectation (round-robin grant order, one
//   flash request per accepted port request, data = mem(address)).
// -----------------------------------------------------------------------------
module tb_flash_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] p0Addr;
    logic          p0Enable;
    logic          p0Ready;
    logic [DW-1:0] p0Data;
    logic [AW-1:0] p1Addr;
    logic          p1Enable;
    logic          p1Ready;
    logic [DW-1:0] p1Data;
    logic [AW-1:0] flashReadAddr;
    logic          enableFlash;
    logic [DW-1:0] fdata;
    logic          fdr;

    int checks;
    int errors;

    // Flash controller model state
    logic [AW-1:0] issued [$];
    int            lat_cfg;
    int            cst;
    int            cnt;
    logic [AW-1:0] cur_addr;

    flash_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .p0Addr         (p0Addr),
        .p0Enable       (p0Enable),
        .p0Ready        (p0Ready),
        .p0Data         (p0Data),
        .p1Addr         (p1Addr),
        .p1Enable       (p1Enable),
        .p1Ready        (p1Ready),
        .p1Data         (p1Data),
        .flashReadAddr  (flashReadAddr),
        .enableFlash    (enableFlash),
        .flashByteRead  (fdata),
        .flashDataReady (fdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash contents as seen by the controller model
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 24'h000010) return 16'hA5A5;
        return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h3C5A;
    endfunction

    // Flash controller: accept, hold ready low for the latency, return data,
    // then wait for the request to drop. Every accepted address is logged.
    always @(posedge clk) begin
        if (reset) begin
            fdr   <= 1'b1;
            fdata <= '0;
            cst   <= 0;
            cnt   <= 0;
        end else begin
            case (cst)
                0: if (enableFlash === 1'b1) begin
                       fdr      <= 1'b0;
                       cur_addr <= flashReadAddr;
                       issued.push_back(flashReadAddr);
                       cnt      <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(6, 1));
                       cst      <= 1;
                   end
                1: if (cnt <= 1) begin
                       fdr   <= 1'b1;
                       fdata <= mem(cur_addr);
                       cst   <= 2;
                   end else begin
                       cnt <= cnt - 1;
                   end
                2: if (enableFlash !== 1'b1) cst <= 0;
                default: cst <= 0;
            endcase
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        p0Enable = 1'b0;
        p1Enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int p, output int n, output bit to);
        to = 1'b1;
        n  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (((p == 0) ? p0Ready : p1Ready) === 1'b1) begin
                n  = c;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_en(input logic lvl, output int n, output bit to);
        to = 1'b1;
        n  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (enableFlash === lvl) begin
                n  = c;
                to = 1'b0;
                break;
            end
        end
    endtask

    // One complete port transaction: raise, wait for Ready, take data, drop.
    task automatic client(input int p, input logic [AW-1:0] a,
                          output logic [DW-1:0] d, output bit to);
        int n;
        if (p == 0) begin
            p0Addr = a; p0Enable = 1'b1;
        end else begin
            p1Addr = a; p1Enable = 1'b1;
        end
        wait_ready(p, n, to);
        d = (p == 0) ? p0Data : p1Data;
        if (p == 0) p0Enable = 1'b0; else p1Enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        p0Addr = AW'($urandom);
        p1Addr = AW'($urandom);
        do_reset();
        checks++; if (p0Ready !== 1'b1) begin errors++; $display("FAIL reset_p0Ready: got %b expected 1", p0Ready); end
        checks++; if (p1Ready !== 1'b1) begin errors++; $display("FAIL reset_p1Ready: got %b expected 1", p1Ready); end
        checks++; if (p0Data !== '0) begin errors++; $display("FAIL reset_p0Data: got %h expected 0", p0Data); end
        checks++; if (p1Data !== '0) begin errors++; $display("FAIL reset_p1Data: got %h expected 0", p1Data); end
        checks++; if (enableFlash !== 1'b0) begin errors++; $display("FAIL reset_enableFlash: got %b expected 0", enableFlash); end
        checks++; if (flashReadAddr !== '0) begin errors++; $display("FAIL reset_flashReadAddr: got %h expected 0", flashReadAddr); end
    endtask

    task automatic test_single_read();
        int n;
        bit to;
        int base;
        lat_cfg = 4;
        base    = issued.size();
        @(negedge clk);
        checks++; if (p0Ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected 1", p0Ready); end
        p0Addr   = 24'h000010;
        p1Addr   = AW'($urandom);
        p0Enable = 1'b1;
        wait_en(1'b1, n, to);
        checks++; if (to || n != 3) begin errors++; $display("FAIL single_issue_latency: got %0d cycles (timeout %0d) expected 3", n, to); end
        checks++; if (flashReadAddr !== 24'h000010) begin errors++; $display("FAIL single_addr: got %h expected 000010", flashReadAddr); end
        checks++; if (p0Ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready: got %b expected 0", p0Ready); end
        // late address changes on either port must not matter
        p0Addr = AW'($urandom);
        p1Addr = AW'($urandom);
        wait_ready(0, n, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout expected p0Ready=1"); end
        checks++; if (p0Data !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h expected a5a5", p0Data); end
        checks++; if (enableFlash !== 1'b0) begin errors++; $display("FAIL single_en_drop: got %b expected 0", enableFlash); end
        checks++; if (issued.size() != base + 1 || issued[base] !== 24'h000010) begin
            errors++; $display("FAIL single_issued: got %0d requests expected 1 at 000010", issued.size() - base);
        end
        p0Enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int            last_m;
        int            first;
        int            base;
        bit            both;
        bit            t0, t1;
        logic [AW-1:0] a0, a1, e0, e1;
        logic [DW-1:0] d0, d1;
        do_reset();
        last_m = 1;
        for (int r = 0; r < 4; r++) begin
            both = (r != 2);
            if (r == 0) begin
                a0 = 24'h000020; a1 = 24'h000040;
            end else begin
                a0 = {1'b0, 23'($urandom)};
                a1 = {1'b1, 23'($urandom)};
            end
            lat_cfg = int'($urandom_range(6, 1));
            base    = issued.size();
            t1      = 1'b0;
            if (both) begin
                fork
                    client(0, a0, d0, t0);
                    client(1, a1, d1, t1);
                join
            end else begin
                client(0, a0, d0, t0);
            end
            first = both ? ((last_m == 0) ? 1 : 0) : 0;
            e0    = (first == 0) ? a0 : a1;
            e1    = (first == 0) ? a1 : a0;
            checks++; if (t0 || t1) begin errors++; $display("FAIL rr_timeout: round %0d got timeout p0=%0d p1=%0d expected none", r, t0, t1); end
            checks++; if (d0 !== mem(a0)) begin errors++; $display("FAIL rr_p0_data: round %0d got %h expected %h", r, d0, mem(a0)); end
            if (both) begin
                checks++; if (d1 !== mem(a1)) begin errors++; $display("FAIL rr_p1_data: round %0d got %h expected %h", r, d1, mem(a1)); end
            end
            checks++; if (issued.size() != base + (both ? 2 : 1) || issued[base] !== e0) begin
                errors++; $display("FAIL rr_first_grant: round %0d got %h expected %h", r, issued[base], e0);
            end
            if (both) begin
                checks++; if (issued.size() != base + 2 || issued[base + 1] !== e1) begin
                    errors++; $display("FAIL rr_second_grant: round %0d got %h expected %h", r, issued[base + 1], e1);
                end
            end
            last_m = both ? (1 - first) : 0;
        end
    endtask

    task automatic test_fairness();
        logic [AW-1:0] a0s [4];
        logic [AW-1:0] a1s [4];
        logic [AW-1:0] exp_a;
        logic [DW-1:0] dq0, dq1;
        bit            tq0, tq1;
        int            base;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a0s[k] = {1'b0, 23'($urandom)};
            a1s[k] = {1'b1, 23'($urandom)};
        end
        lat_cfg = 0;
        base    = issued.size();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    client(0, a0s[k], dq0, tq0);
                    checks++; if (tq0 || dq0 !== mem(a0s[k])) begin errors++; $display("FAIL fair_p0_data: txn %0d got %h (timeout %0d) expected %h", k, dq0, tq0, mem(a0s[k])); end
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    client(1, a1s[k], dq1, tq1);
                    checks++; if (tq1 || dq1 !== mem(a1s[k])) begin errors++; $display("FAIL fair_p1_data: txn %0d got %h (timeout %0d) expected %h", k, dq1, tq1, mem(a1s[k])); end
                end
            end
        join
        checks++; if (issued.size() != base + 8) begin errors++; $display("FAIL fair_count: got %0d requests expected 8", issued.size() - base); end
        for (int k = 0; k < 8; k++) begin
            exp_a = (k % 2 == 0) ? a0s[k / 2] : a1s[k / 2];
            checks++; if (base + k >= issued.size() || issued[base + k] !== exp_a) begin
                errors++; $display("FAIL fair_order: slot %0d got %h expected %h", k, issued[base + k], exp_a);
            end
        end
    endtask

    task automatic test_held_enable();
        logic [AW-1:0] a, a2;
        int            n;
        bit            to;
        bit            low_seen;
        int            base;
        lat_cfg = 3;
        base    = issued.size();
        a       = AW'($urandom);
        p1Addr   = a;
        p1Enable = 1'b1;
        wait_ready(1, n, to);
        checks++; if (to || p1Data !== mem(a)) begin errors++; $display("FAIL held_first_data: got %h (timeout %0d) expected %h", p1Data, to, mem(a)); end
        low_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (p1Ready !== 1'b1) low_seen = 1'b1;
        end
        checks++; if (low_seen) begin errors++; $display("FAIL held_ready: got Ready low while held expected 1"); end
        checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL held_no_reissue: got %0d requests expected 1", issued.size() - base); end
        p1Enable = 1'b0;
        @(negedge clk);
        a2       = AW'($urandom);
        p1Addr   = a2;
        p1Enable = 1'b1;
        wait_ready(1, n, to);
        checks++; if (to || p1Data !== mem(a2)) begin errors++; $display("FAIL held_second_data: got %h (timeout %0d) expected %h", p1Data, to, mem(a2)); end
        p1Enable = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (issued.size() != base + 2 || issued[base + 1] !== a2) begin
            errors++; $display("FAIL held_one_new: got %0d requests expected 2", issued.size() - base);
        end
    endtask

    task automatic test_abort();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d1_before;
        int            n;
        bit            to;
        int            base;
        lat_cfg   = 8;
        d1_before = p1Data;
        base      = issued.size();
        a0        = {1'b0, 23'($urandom)};
        a1        = {1'b1, 23'($urandom)};
        // abort after grant: p1 owns the flash, p0 waits behind it
        p1Addr   = a1;
        p1Enable = 1'b1;
        @(negedge clk);
        p0Addr   = a0;
        p0Enable = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fdr === 1'b0) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL abort_accept: got timeout expected controller accept"); end
        @(negedge clk);
        p1Enable = 1'b0;
        @(negedge clk);
        checks++; if (p1Ready !== 1'b0) begin errors++; $display("FAIL abort_inflight_ready: got %b expected 0", p1Ready); end
        wait_en(1'b0, n, to);
        checks++; if (to || p1Ready !== 1'b1) begin errors++; $display("FAIL abort_done_ready: got %b (timeout %0d) expected 1", p1Ready, to); end
        checks++; if (p1Data !== d1_before) begin errors++; $display("FAIL abort_data_kept: got %h expected %h", p1Data, d1_before); end
        wait_ready(0, n, to);
        checks++; if (to || p0Data !== mem(a0)) begin errors++; $display("FAIL abort_p0_data: got %h (timeout %0d) expected %h", p0Data, to, mem(a0)); end
        checks++; if (issued.size() != base + 2 || issued[base] !== a1 || issued[base + 1] !== a0) begin
            errors++; $display("FAIL abort_order: got %0d requests expected p1 %h then p0 %h", issued.size() - base, a1, a0);
        end
        p0Enable = 1'b0;
        @(negedge clk);

        // abort before grant: p1 gives up while p0 owns the flash
        base     = issued.size();
        a0       = {1'b0, 23'($urandom)};
        p0Addr   = a0;
        p0Enable = 1'b1;
        wait_en(1'b1, n, to);
        p1Addr   = AW'($urandom);
        p1Enable = 1'b1;
        @(negedge clk);
        checks++; if (p1Ready !== 1'b0) begin errors++; $display("FAIL pregrant_pending: got %b expected 0", p1Ready); end
        p1Enable = 1'b0;
        @(negedge clk);
        checks++; if (p1Ready !== 1'b1) begin errors++; $display("FAIL pregrant_ready: got %b expected 1", p1Ready); end
        checks++; if (p1Data !== d1_before) begin errors++; $display("FAIL pregrant_data: got %h expected %h", p1Data, d1_before); end
        wait_ready(0, n, to);
        checks++; if (to || p0Data !== mem(a0)) begin errors++; $display("FAIL pregrant_p0_data: got %h (timeout %0d) expected %h", p0Data, to, mem(a0)); end
        p0Enable = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (issued.size() != base + 1) begin errors++; $display("FAIL pregrant_no_issue: got %0d requests expected 1", issued.size() - base); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit to;
        bit bad;
        lat_cfg  = 4;
        p0Addr   = {1'b0, 23'($urandom)};
        p0Enable = 1'b1;
        @(negedge clk);
        p1Addr   = AW'($urandom);
        p1Enable = 1'b1;
        wait_en(1'b1, n, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_issue: got timeout expected enableFlash=1"); end
        reset    = 1'b1;
        p0Enable = 1'b0;
        p1Enable = 1'b0;
        @(negedge clk);
        checks++; if (enableFlash !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b expected 0", enableFlash); end
        checks++; if (p0Ready !== 1'b1 || p1Ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b%b expected 11", p1Ready, p0Ready); end
        checks++; if (p0Data !== '0 || p1Data !== '0) begin errors++; $display("FAIL rmid_data: got %h %h expected 0 0", p0Data, p1Data); end
        reset = 1'b0;
        bad   = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (enableFlash !== 1'b0 || p0Data !== '0 || p0Ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rmid_quiet: got activity after reset expected none"); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        lat_cfg  = 4;
        reset    = 1'b1;
        p0Addr   = '0;
        p1Addr   = '0;
        p0Enable = 1'b0;
        p1Enable = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fairness();
        test_held_enable();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
